// File: rtl/present_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : present_pkg                                               |
// | Brief    : PRESENT-80 widths, FSM states, S-box and key update       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package present_pkg;

    localparam int KEY_W = 80;
    localparam int BLK_W = 64;
    localparam int RC_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Rotate left by 61 is the same as rotate right by 19.
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t         = {k[18:0], k[KEY_W-1:19]};
        t[79:76]  = sbox(t[79:76]);
        t[19:15]  = t[19:15] ^ rc;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : present_player                                            |
// | Brief    : PRESENT bit permutation, bit i -> 16*i mod 63, bit 63 kept|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module present_player
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] i_data,
    output logic [BLK_W-1:0] o_data
);

    for (genvar i = 0; i < BLK_W-1; i++) begin : g_bit
        assign o_data[(16*i) % 63] = i_data[i];
    end
    assign o_data[BLK_W-1] = i_data[BLK_W-1];

endmodule
`default_nettype wire

// File: rtl/present_slayer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : present_slayer                                            |
// | Brief    : 64-bit PRESENT substitution layer, 16 parallel S-boxes    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module present_slayer
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] i_data,
    output logic [BLK_W-1:0] o_data
);

    for (genvar n = 0; n < BLK_W/4; n++) begin : g_nib
        assign o_data[4*n +: 4] = sbox(i_data[4*n +: 4]);
    end

endmodule
`default_nettype wire

// File: rtl/present80_enc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : present80_enc_core                                        |
// | Brief    : Iterative PRESENT-80 encryptor, one round per clock       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module present80_enc_core
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_pt,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_ct,
    output logic             busy
);

    localparam logic [RC_W-1:0] c_last_rc = RC_W'(ROUNDS);

    fsm_t             r_fsm;
    logic [BLK_W-1:0] r_state;
    logic [KEY_W-1:0] r_key;
    logic [RC_W-1:0]  r_rc;

    logic [BLK_W-1:0] w_ark;
    logic [BLK_W-1:0] w_sl;
    logic [BLK_W-1:0] w_pl;
    logic [KEY_W-1:0] w_key_nxt;

    assign w_ark     = r_state ^ r_key[KEY_W-1 -: BLK_W];
    assign w_key_nxt = key_update(r_key, r_rc);

    present_slayer u_slayer (
        .i_data (w_ark),
        .o_data (w_sl)
    );

    present_player u_player (
        .i_data (w_sl),
        .o_data (w_pl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_state   <= '0;
            r_key     <= '0;
            r_rc      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_ct    <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        r_state  <= in_pt;
                        r_key    <= in_key;
                        r_rc     <= RC_W'(1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_fsm    <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_pl;
                    r_key   <= w_key_nxt;
                    r_rc    <= r_rc + 1'b1;
                    // Final whitening uses the key produced by this last update.
                    if (r_rc == c_last_rc) begin
                        out_ct    <= w_pl ^ w_key_nxt[KEY_W-1 -: BLK_W];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_fsm     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_fsm     <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_present80_enc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_present80_enc_core                                     |
// | Brief    : Scoreboard bench for present80_enc_core (31 and 1 rounds) |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_present80_enc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [63:0] in_pt = '0, out_ct;
    logic [79:0] in_key = '0;
    logic        in1_valid = 1'b0, in1_ready, out1_valid, out1_ready = 1'b1, busy1;
    logic [63:0] in1_pt = '0, out1_ct;
    logic [79:0] in1_key = '0;

    int checks = 0, failures = 0, cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp1_q[$];
    logic [3:0]  sb_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present80_enc_core #(.ROUNDS(31)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt),
        .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .busy(busy));

    present80_enc_core #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_pt(in1_pt),
        .in_key(in1_key), .out_valid(out1_valid), .out_ready(out1_ready), .out_ct(out1_ct), .busy(busy1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference cipher straight from the algorithm description, bit by bit.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key, input int rounds);
        logic [63:0] s, t;
        logic [79:0] k;
        logic [4:0]  rc;
        s = pt;
        k = key;
        for (int r = 1; r <= rounds; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = sb_tab[s[4*n +: 4]];
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16*i) % 63] = t[i];
            k = (k << 61) | (k >> 19);
            k[79:76] = sb_tab[k[79:76]];
            rc = r[4:0];
            k[19:15] = k[19:15] ^ rc;
        end
        return s ^ k[79:16];
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("ct_unexpected", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("ct", out_ct, e);
            end
        end
        if (!rst && out1_valid && out1_ready) begin
            if (exp1_q.size() == 0) chk("ct1_unexpected", 64'd1, 64'd0);
            else begin
                e = exp1_q.pop_front();
                chk("ct1", out1_ct, e);
            end
        end
    end

    task automatic send(input logic [63:0] pt, input logic [79:0] key, input bit push,
                        input logic [63:0] exp, output int acc);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        if (push) exp_q.push_back(exp);
        in_valid = 1'b1; in_pt = pt; in_key = key;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        in_pt  = {$urandom, $urandom};
        in_key = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int acc, input int rounds);
        int n = 0;
        bit bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad = 1;
            @(posedge clk); #1; n++;
        end
        if (in_ready) bad = 1;
        chk("out_valid_timeout", 64'(out_valid), 64'd1);
        chk("latency", 64'(cyc - acc + 1), 64'(rounds + 1));
        chk("in_ready_low_run", 64'(bad), 64'd0);
    endtask

    task automatic run_vec(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] exp);
        int acc;
        send(pt, key, 1'b1, exp, acc);
        wait_done(acc, 31);
        @(posedge clk); #1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        chk("out_valid_idle", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n;
        logic [63:0] held, pt;
        logic [79:0] key;

        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ct", out_ct, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        chk("model_kat", ref_enc(64'd0, 80'd0, 31), 64'h5579C1387B228445);

        run_vec(64'h0, 80'h0, 64'h5579C1387B228445);
        run_vec(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
        run_vec({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
        run_vec({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
        for (int v = 0; v < 6; v++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom};
            run_vec(pt, key, ref_enc(pt, key, 31));
        end

        // Consumer stalls for 20 cycles; in_valid pulses must be ignored.
        out_ready = 1'b0;
        pt  = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom};
        send(pt, key, 1'b1, ref_enc(pt, key, 31), acc);
        wait_done(acc, 31);
        held = out_ct;
        begin
            bit unstable = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid = c[0];
                in_pt  = {$urandom, $urandom};
                in_key = {$urandom, $urandom, $urandom};
                @(posedge clk); #1;
                if (!out_valid || out_ct !== held || in_ready || busy) unstable = 1;
            end
            chk("hold_stable", 64'(unstable), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", 64'(out_valid), 64'd0);
        chk("hold_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("hold_no_accept_busy", 64'(busy), 64'd0);

        // Reset mid-run discards the block.
        send(64'h0123456789ABCDEF, 80'h1, 1'b0, 64'd0, acc);
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out_ct", out_ct, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(64'h0, 80'h0, 64'h5579C1387B228445);

        // Single-round instance.
        for (int v = 0; v < 2; v++) begin
            pt  = (v == 0) ? 64'd0 : {$urandom, $urandom};
            key = (v == 0) ? 80'd0 : {$urandom, $urandom, $urandom};
            n = 0;
            while (!in1_ready && n < 50) begin @(posedge clk); #1; n++; end
            exp1_q.push_back(ref_enc(pt, key, 1));
            in1_valid = 1'b1; in1_pt = pt; in1_key = key;
            @(posedge clk); #1;
            acc = cyc;
            in1_valid = 1'b0;
            n = 0;
            while (!out1_valid && n < 20) begin @(posedge clk); #1; n++; end
            chk("r1_latency", 64'(cyc - acc + 1), 64'd2);
            @(posedge clk); #1;
        end

        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("scoreboard_empty", 64'(exp_q.size() + exp1_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
